alarm_clock_core: RTL and testbench
===================================

# alarm_clock_core

Parametrised timekeeping and multi-alarm core for the lab clock. It is the successor to the single-alarm, 12-hour top level.
- Keeps seconds, minutes, 24-hour hours and day-of-week.
- Holds `NUM_ALARMS` independent alarms, each with a day mask and its own ring/snooze state machine.
- Presents display-ready 12h or 24h values to the existing `lcd_int` drivers, which sit outside this block.

## Interface
Parameters:
- `NUM_ALARMS`, 4: number of alarm channels (1..8).
- `SNOOZE_MIN`, 9: snooze length in minutes (1..59).
- `RING_SEC`, 60: seconds an unanswered alarm rings before auto-clearing (1..255).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle strobe, once per second; all time and button actions qualify on it.
- `timeset`, `alarmset`  in  1: mode buttons; `timeset` has priority when both are high.
- `minadv`, `hrsadv`, `dayadv`  in  1: advance buttons.
- `alarm_sel`  in  $clog2(NUM_ALARMS): channel being edited or displayed.
- `mask_wr`  in  1 / `mask_in`  in  7: writes the day mask of `alarm_sel` on `tick` while `alarmset` is high; bit0 = day 0.
- `alarm_en`  in  NUM_ALARMS: per-channel arm.
- `snooze`, `dismiss`  in  1: act on all ringing channels.
- `mode24`  in  1: display format select.
- `disp_sec`, `disp_min`  out  6: display seconds and minutes.
- `disp_hrs`  out  5: display hours.
- `disp_pm`  out  1: PM indicator.
- `day`  out  3: day of week, 0..6.
- `ringing`  out  NUM_ALARMS: per-channel ring status.
- `snoozed`  out  NUM_ALARMS: per-channel snooze status.
- `buzz`  out  1: OR of `ringing`.

## Operation
- **Internal time.** sec 0..59, min 0..59, hr 0..23, day 0..6. The carry chain runs sec→min→hr→day on `tick` when `timeset` is low.
- **Time set (`timeset` high).**
  - Seconds hold.
  - On `tick`: `minadv` → min+1 mod 60; `hrsadv` → hr+1 mod 24; `dayadv` → day+1 mod 7.
  - No carries between fields; simultaneous buttons each apply.
- **Alarm set (`alarmset` high, `timeset` low).**
  - Time keeps running.
  - `minadv`/`hrsadv` advance the selected alarm's min/hr the same way, with no carry.
  - `mask_wr` loads `mask_in` into the selected alarm's mask.
- **Display selection.** `disp_min`/`disp_hrs`/`disp_pm` show the selected alarm while `alarmset` is high and time otherwise. `disp_sec` always shows time.
- **Display format.**
  - `mode24` = 1: `disp_hrs` = hr, `disp_pm` = 0.
  - `mode24` = 0: `disp_hrs` = hr mod 12, with 0 shown as 12; `disp_pm` = (hr ≥ 12).
- **Alarm match.** A `tick` that moves time to the alarm's hr:min:00 triggers a match when:
  - `alarm_en[i]` is set,
  - the alarm's mask bit for the new day is set, and
  - `timeset` is low.
- **Per-channel FSM.**
  - IDLE → RINGING on match.
  - RINGING → IDLE on `dismiss`, or when the ring counter reaches `RING_SEC`.
  - RINGING → SNOOZED on `snooze`; the countdown loads `SNOOZE_MIN*60`.
  - SNOOZED: countdown decrements on `tick`; → RINGING when it reaches 0, with the ring counter cleared.
  - SNOOZED → IDLE on `dismiss`.
  - Any state → IDLE when `alarm_en[i]` drops.
- **Simultaneous events.**
  - `dismiss` beats `snooze`.
  - `snooze` beats timeout on the same cycle.
  - A new match while SNOOZED restarts RINGING.
  - A match while RINGING clears the ring counter.
- `snooze`/`dismiss` act on the cycle they are high; no `tick` is required.

## Timing
- **Reset values.** All state clears asynchronously on `rst_n` low:
  - time = 00:00:00, day 0;
  - all alarms at 00:00 with mask 7'h7F;
  - all FSMs IDLE, counters 0.
- **Outputs after reset.** `disp_hrs` = 12 (12h mode) or 0 (24h mode); `disp_pm`, `ringing`, `snoozed` and `buzz` = 0.
- **Registered updates.** Time, alarm registers and FSM state update on the `clk` edge where `tick` (or `snooze`/`dismiss`) is sampled.
- **`ringing`/`buzz` latency.** Assert on the same edge that time becomes hh:mm:00 (registered FSM outputs), i.e. zero cycles after the time update.
- **Display outputs.** Combinational from registers.
- **Ring duration.** An unanswered ring lasts exactly `RING_SEC` ticks.
- **Snooze duration.** Exactly `SNOOZE_MIN*60` ticks elapse from the `snooze` cycle to re-ring.
- **Reset mid-ring.** Asserting `rst_n` low mid-ring drops `buzz` immediately, asynchronously.

## Structure
- **Package `clock_pkg`.** Holds:
  - the alarm state enum (IDLE, RINGING, SNOOZED);
  - constants SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23, DAY_MAX = 6;
  - the struct `alarm_t` {hr[4:0], min[5:0], mask[6:0]}.
- **Sub-module `alarm_channel`.** One instance per channel, built in a generate loop. It owns the alarm registers, match compare, FSM, ring counter and snooze countdown.
- **Top level.** Holds the time counters, edit decode and display mux.

## Test plan
- **Rollover.** Reset, set time to 23:59:58 day 6, 2 ticks → 00:00:00, day 0; 12h display 12 AM; `mode24` → `disp_hrs` 0.
- **Time set.** `timeset`+`minadv` at 10:59 for 1 tick → 10:00, hr unchanged, seconds frozen; `hrsadv` at 23 → 0, day unchanged.
- **Match, ring and timeout.**
  - Alarm 1 at 07:30, mask = day 2 only.
  - Run through 07:30:00 on day 1 → no ring.
  - On day 2 → `ringing[1]` = 1 at 07:30:00.
  - Clears after `RING_SEC` ticks with no input.
- **Snooze.** `snooze` at 07:30:05 → `snoozed[1]` = 1, `buzz` 0; re-ring exactly 540 ticks later (07:39:05); then `dismiss` → IDLE.
- **Priority.** `snooze` and `dismiss` in the same cycle → IDLE. Two channels matching the same minute → both ring, single `snooze` snoozes both. `alarm_en` drop mid-snooze → IDLE.
- **Async reset.** Assert `rst_n` low asynchronously mid-ring, between clocks → `buzz` 0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared alarm state, time limits, alarm record and wrap-increment helper
package clock_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RINGING = 2'b01, SNOOZED = 2'b10} alarm_state_e;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HR_MAX = 6'd23;
  localparam logic [5:0] DAY_MAX = 6'd6;
  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [6:0] mask;
  } alarm_t;
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] m);
    return (v == m) ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm's registers, match compare, ring/snooze FSM and counters
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       run,
  input  logic       edit,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       mask_wr,
  input  logic [6:0] mask_in,
  input  logic       en,
  input  logic       snooze,
  input  logic       dismiss,
  input  logic [5:0] sec_nx,
  input  logic [5:0] min_nx,
  input  logic [4:0] hr_nx,
  input  logic [2:0] day_nx,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic       ringing,
  output logic       snoozed
);
  localparam logic [11:0] SNZ_TICKS = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
  alarm_t cfg_q, cfg_d;
  alarm_state_e st_q, st_d;
  logic [7:0] ring_q, ring_d;
  logic [11:0] snz_q, snz_d;
  logic match;
  always_comb begin
    cfg_d.min = (edit & minadv) ? wrap_inc(cfg_q.min, MIN_MAX) : cfg_q.min;
    cfg_d.hr = (edit & hrsadv) ? 5'(wrap_inc(6'(cfg_q.hr), HR_MAX)) : cfg_q.hr;
    cfg_d.mask = (edit & mask_wr) ? mask_in : cfg_q.mask;
    match = en & run & (sec_nx == 6'd0) & (min_nx == cfg_q.min) & (hr_nx == cfg_q.hr) & cfg_q.mask[day_nx];
  end
  always_comb begin
    st_d = st_q;
    ring_d = ring_q;
    snz_d = snz_q;
    if (!en || (st_q != IDLE && dismiss)) begin
      st_d = IDLE;
      ring_d = '0;
      snz_d = '0;
    end else if (st_q == IDLE) begin
      st_d = match ? RINGING : IDLE;
      ring_d = '0;
    end else if (st_q == RINGING) begin
      if (snooze) begin
        st_d = SNOOZED;
        snz_d = SNZ_TICKS;
      end else if (match) begin
        ring_d = '0;
      end else if (tick) begin
        st_d = (ring_q == RING_LAST) ? IDLE : RINGING;
        ring_d = (ring_q == RING_LAST) ? 8'd0 : ring_q + 8'd1;
      end
    end else if (match || (tick && snz_q <= 12'd1)) begin
      st_d = RINGING;
      ring_d = '0;
      snz_d = '0;
    end else if (tick) begin
      snz_d = snz_q - 12'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '{hr: 5'd0, min: 6'd0, mask: 7'h7F};
      st_q <= IDLE;
      ring_q <= '0;
      snz_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      st_q <= st_d;
      ring_q <= ring_d;
      snz_q <= snz_d;
    end
  end
  assign hr = cfg_q.hr;
  assign min = cfg_q.min;
  assign ringing = st_q[0];
  assign snoozed = st_q[1];
endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24h time/day counters, alarm edit decode, multi-alarm channels and 12h/24h display mux
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC = 60,
  localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  timeset,
  input  logic                  alarmset,
  input  logic                  minadv,
  input  logic                  hrsadv,
  input  logic                  dayadv,
  input  logic [SW-1:0]         alarm_sel,
  input  logic                  mask_wr,
  input  logic [6:0]            mask_in,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  input  logic                  mode24,
  output logic [5:0]            disp_sec,
  output logic [5:0]            disp_min,
  output logic [4:0]            disp_hrs,
  output logic                  disp_pm,
  output logic [2:0]            day,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic [NUM_ALARMS-1:0] snoozed,
  output logic                  buzz
);
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d, h, h12;
  logic [2:0] day_q, day_d;
  logic run, set, c_min, c_hr, c_day;
  logic [4:0] a_hr [NUM_ALARMS];
  logic [5:0] a_min [NUM_ALARMS];
  always_comb begin
    run = tick & ~timeset;
    set = tick & timeset;
    c_min = run & (sec_q == SEC_MAX);
    c_hr = c_min & (min_q == MIN_MAX);
    c_day = c_hr & (6'(hr_q) == HR_MAX);
    sec_d = run ? wrap_inc(sec_q, SEC_MAX) : sec_q;
    min_d = (c_min | (set & minadv)) ? wrap_inc(min_q, MIN_MAX) : min_q;
    hr_d = (c_hr | (set & hrsadv)) ? 5'(wrap_inc(6'(hr_q), HR_MAX)) : hr_q;
    day_d = (c_day | (set & dayadv)) ? 3'(wrap_inc(6'(day_q), DAY_MAX)) : day_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q <= '0;
      day_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q <= hr_d;
      day_q <= day_d;
    end
  end
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .run(run),
      .edit(tick & alarmset & ~timeset & (alarm_sel == SW'(i))),
      .minadv(minadv),
      .hrsadv(hrsadv),
      .mask_wr(mask_wr),
      .mask_in(mask_in),
      .en(alarm_en[i]),
      .snooze(snooze),
      .dismiss(dismiss),
      .sec_nx(sec_d),
      .min_nx(min_d),
      .hr_nx(hr_d),
      .day_nx(day_d),
      .hr(a_hr[i]),
      .min(a_min[i]),
      .ringing(ringing[i]),
      .snoozed(snoozed[i])
    );
  end
  always_comb begin
    h = alarmset ? a_hr[alarm_sel] : hr_q;
    h12 = (h >= 5'd12) ? h - 5'd12 : h;
    disp_hrs = mode24 ? h : ((h12 == 5'd0) ? 5'd12 : h12);
    disp_pm = ~mode24 & (h >= 5'd12);
    disp_min = alarmset ? a_min[alarm_sel] : min_q;
  end
  assign disp_sec = sec_q;
  assign day = day_q;
  assign buzz = |ringing;
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed self-checking bench for rollover, time/alarm set, ring, snooze, priority and async reset
module tb_alarm_clock_core;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, timeset = 1'b0, alarmset = 1'b0;
  logic minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0, mask_wr = 1'b0;
  logic snooze = 1'b0, dismiss = 1'b0, mode24 = 1'b0;
  logic [1:0] alarm_sel = 2'd0;
  logic [6:0] mask_in = 7'd0;
  logic [3:0] alarm_en = 4'd0;
  logic [5:0] disp_sec, disp_min;
  logic [4:0] disp_hrs;
  logic disp_pm, buzz;
  logic [2:0] day;
  logic [3:0] ringing, snoozed;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alarm_clock_core #(.NUM_ALARMS(4), .SNOOZE_MIN(9), .RING_SEC(60)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv), .alarm_sel(alarm_sel),
    .mask_wr(mask_wr), .mask_in(mask_in), .alarm_en(alarm_en), .snooze(snooze),
    .dismiss(dismiss), .mode24(mode24), .disp_sec(disp_sec), .disp_min(disp_min),
    .disp_hrs(disp_hrs), .disp_pm(disp_pm), .day(day), .ringing(ringing),
    .snoozed(snoozed), .buzz(buzz)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tk(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_t(input string tag, input int h, input int m, input int s, input int pm);
    chk({tag, "_hrs"}, int'(disp_hrs), h);
    chk({tag, "_min"}, int'(disp_min), m);
    chk({tag, "_sec"}, int'(disp_sec), s);
    chk({tag, "_pm"}, int'(disp_pm), pm);
  endtask
  task automatic chk_a(input string tag, input int r, input int s, input int b);
    chk({tag, "_ringing"}, int'(ringing), r);
    chk({tag, "_snoozed"}, int'(snoozed), s);
    chk({tag, "_buzz"}, int'(buzz), b);
  endtask
  initial begin
    repeat (2) cyc();
    chk_t("reset", 12, 0, 0, 0);
    chk("reset_day", int'(day), 0);
    chk_a("reset", 0, 0, 0);
    mode24 = 1'b1; #1;
    chk("reset_24h", int'(disp_hrs), 0);
    mode24 = 1'b0; #1;
    rst_n = 1'b1;
    cyc();
    timeset = 1'b1; minadv = 1'b1; hrsadv = 1'b1; dayadv = 1'b1; tk(6);
    dayadv = 1'b0; tk(17);
    hrsadv = 1'b0; tk(35);
    timeset = 1'b0; minadv = 1'b0; tk(118);
    chk_t("pre_roll", 11, 59, 58, 1);
    chk("pre_roll_day", int'(day), 6);
    tk(2);
    chk_t("roll", 12, 0, 0, 0);
    chk("roll_day", int'(day), 0);
    mode24 = 1'b1; #1;
    chk("roll_24h_hrs", int'(disp_hrs), 0);
    chk("roll_24h_pm", int'(disp_pm), 0);
    mode24 = 1'b0; #1;
    tk(7);
    timeset = 1'b1; hrsadv = 1'b1; tk(10);
    hrsadv = 1'b0; minadv = 1'b1; tk(59);
    chk_t("set_1059", 10, 59, 7, 0);
    tk(1);
    chk_t("set_minwrap", 10, 0, 7, 0);
    minadv = 1'b0; hrsadv = 1'b1; tk(13);
    chk_t("set_23", 11, 0, 7, 1);
    tk(1);
    chk_t("set_hrwrap", 12, 0, 7, 0);
    chk("set_hrwrap_day", int'(day), 0);
    hrsadv = 1'b0; timeset = 1'b0;
    alarmset = 1'b1; alarm_sel = 2'd1; hrsadv = 1'b1; tk(7);
    hrsadv = 1'b0; minadv = 1'b1; tk(30);
    minadv = 1'b0; mask_wr = 1'b1; mask_in = 7'b0000100; tk(1);
    mask_wr = 1'b0;
    chk_t("alarm1_disp", 7, 30, 45, 0);
    alarmset = 1'b0; #1;
    chk_t("time_after_edit", 12, 0, 45, 0);
    tk(15);
    timeset = 1'b1; dayadv = 1'b1; tk(1);
    dayadv = 1'b0; hrsadv = 1'b1; tk(7);
    hrsadv = 1'b0; minadv = 1'b1; tk(28);
    minadv = 1'b0; timeset = 1'b0;
    chk_t("d1_0729", 7, 29, 0, 0);
    chk("d1_day", int'(day), 1);
    alarm_en = 4'b0010;
    tk(60);
    chk_t("d1_0730", 7, 30, 0, 0);
    chk_a("d1_nomatch", 0, 0, 0);
    timeset = 1'b1; dayadv = 1'b1; minadv = 1'b1; tk(1);
    dayadv = 1'b0; tk(58);
    minadv = 1'b0; timeset = 1'b0;
    chk_t("d2_0729", 7, 29, 0, 0);
    chk("d2_day", int'(day), 2);
    tk(59);
    chk_a("d2_072959", 0, 0, 0);
    tk(1);
    chk_a("d2_match", 'b0010, 0, 1);
    tk(59);
    chk_a("ring_59", 'b0010, 0, 1);
    tk(1);
    chk_a("ring_timeout", 0, 0, 0);
    chk_t("ring_timeout", 7, 31, 0, 0);
    timeset = 1'b1; minadv = 1'b1; tk(58);
    minadv = 1'b0; timeset = 1'b0;
    tk(60);
    chk_a("rering_0730", 'b0010, 0, 1);
    tk(5);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_a("snooze", 0, 'b0010, 0);
    chk_t("snooze_time", 7, 30, 5, 0);
    tk(539);
    chk_a("snooze_539", 0, 'b0010, 0);
    tk(1);
    chk_a("snooze_540", 'b0010, 0, 1);
    chk_t("snooze_540", 7, 39, 5, 0);
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
    chk_a("dismiss", 0, 0, 0);
    alarmset = 1'b1; alarm_sel = 2'd2; hrsadv = 1'b1; minadv = 1'b1; tk(7);
    hrsadv = 1'b0; tk(33);
    alarm_sel = 2'd1; tk(10);
    minadv = 1'b0;
    chk_t("alarm1_0740", 7, 40, 55, 0);
    alarm_sel = 2'd2; #1;
    chk_t("alarm2_0740", 7, 40, 55, 0);
    alarmset = 1'b0; alarm_en = 4'b0110;
    tk(5);
    chk_a("two_match", 'b0110, 0, 1);
    chk_t("two_match", 7, 40, 0, 0);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_a("two_snooze", 0, 'b0110, 0);
    alarm_en = 4'b0100; cyc();
    chk_a("en_drop", 0, 'b0100, 0);
    timeset = 1'b1; minadv = 1'b1; tk(59);
    minadv = 1'b0; timeset = 1'b0;
    chk_t("back_0739", 7, 39, 0, 0);
    tk(60);
    chk_a("match_in_snooze", 'b0100, 0, 1);
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    chk_a("snz_dis", 0, 0, 0);
    timeset = 1'b1; minadv = 1'b1; tk(59);
    minadv = 1'b0; timeset = 1'b0;
    tk(60);
    chk_a("pre_rst", 'b0100, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0);
    chk_t("async_rst", 12, 0, 0, 0);
    chk("async_rst_day", int'(day), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
